// File: rtl/down_counter_tc_if.sv
// Load/count bus of down_counter_tc: load handshake, count control and status.
// Handshake: a load transfers on a rising clk edge where load_valid && load_ready;
// the requester holds D and load_valid steady until that edge, and load_ready never
// depends combinationally on load_valid.
interface down_counter_tc_if #(
  parameter int N = 16
);
  logic [N-1:0] D;
  logic         load_valid;
  logic         load_ready;
  logic         enable;
  logic         abort;
  logic [N-1:0] Q;
  logic         busy;
  logic         done;
  logic         tc;
  logic [1:0]   state;  // debug view of the counter FSM (0 IDLE, 1 RUN, 2 DONE)

  modport master (
    output D, load_valid, enable, abort,
    input  load_ready, Q, busy, done, tc, state
  );

  modport slave (
    input  D, load_valid, enable, abort,
    output load_ready, Q, busy, done, tc, state
  );
endinterface

// File: rtl/down_counter_tc.sv
// Loadable down-counter with a one-cycle terminal-count pulse, used to time
// FIR tap/sample windows; optional auto-reload for periodic windows.
module down_counter_tc #(
  parameter int N           = 16,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  down_counter_tc_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q;
  logic [N-1:0] cnt_q;
  logic [N-1:0] reload_q;
  logic         tc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      case (state_q)
        RUN: begin
          // abort outranks both decrement and terminal count
          if (bus.abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (bus.enable) begin
            if (cnt_q == ONE) begin
              tc_q <= 1'b1;
              if (AUTO_RELOAD) begin
                cnt_q <= reload_q;
              end else begin
                cnt_q   <= '0;
                state_q <= DONE;
              end
            end else begin
              cnt_q <= cnt_q - ONE;
            end
          end
        end
        IDLE, DONE: begin
          // a pending load beats abort outside RUN
          if (bus.load_valid) begin
            cnt_q    <= bus.D;
            reload_q <= bus.D;
            if (bus.D == '0) begin
              state_q <= DONE;
              tc_q    <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end else if (bus.abort) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.Q          = cnt_q;
  assign bus.tc         = tc_q;
  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.load_ready = (state_q != RUN);
  assign bus.state      = state_q;

endmodule
